serial_mag_comparator: RTL and testbench

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_mag_comparator.sv | 105 ++++++++++
 tb/tb_serial_mag_comparator.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: operands arrive MSB first, one pair per accepted
// transfer; the first differing pair decides the relation, the rest are still consumed.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a,
    input  logic b,
    output logic bit_ready,
    output logic busy,
    output logic done,
    output logic lt,
    output logic gt,
    output logic eq
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] REL_EQ = 2'd0;
    localparam logic [1:0] REL_LT = 2'd1;
    localparam logic [1:0] REL_GT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    rel_q, rel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_q, dec_d;
    logic          lt_q, lt_d;
    logic          gt_q, gt_d;
    logic          eq_q, eq_d;

    always_comb begin
        state_d = state_q;
        rel_d   = rel_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        case (state_q)
            S_IDLE: begin
                // A bit pair presented alongside start is deliberately not consumed.
                if (start) begin
                    state_d = S_CMP;
                    cnt_d   = '0;
                    dec_d   = 1'b0;
                    rel_d   = REL_EQ;
                end
            end
            S_CMP: begin
                if (bit_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!dec_q && (a != b)) begin
                        dec_d = 1'b1;
                        rel_d = a ? REL_GT : REL_LT;
                    end
                    // Result uses rel_d so a decision on the final bit is captured.
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                        lt_d    = (rel_d == REL_LT);
                        gt_d    = (rel_d == REL_GT);
                        eq_d    = (rel_d == REL_EQ);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rel_q   <= REL_EQ;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy      = (state_q == S_CMP);
    assign bit_ready = (state_q == S_CMP);
    assign done      = (state_q == S_DONE);
    assign lt        = lt_q;
    assign gt        = gt_q;
    assign eq        = eq_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomized bench for serial_mag_comparator; expected relation comes from integer compare.
module tb_serial_mag_comparator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, start, bit_valid, a, b;
    logic bit_ready, busy, done, lt, gt, eq;

    int checks = 0;
    int failures = 0;
    logic [2:0] prev_res;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .a(a), .b(b), .bit_ready(bit_ready), .busy(busy), .done(done),
        .lt(lt), .gt(gt), .eq(eq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_rel(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x < y) return 3'b100;
        if (x > y) return 3'b010;
        return 3'b001;
    endfunction

    // mode: 0 continuous valid, 1 valid every other cycle, 2 random valid + stray starts
    task automatic run_cmp(input logic [W-1:0] va, input logic [W-1:0] vb, input int mode);
        int n = 0;
        int cyc = 0;
        logic v;
        logic [2:0] exp_res = ref_rel(va, vb);
        check("idle_busy", busy, 0);
        start = 1'b1;
        bit_valid = 1'b1;
        a = va[W-1];
        b = ~vb[W-1];
        @(posedge clk); #1;
        start = 1'b0;
        check("cmp_busy", {busy, bit_ready, done}, 3'b110);
        check("hold_at_start", {lt, gt, eq}, prev_res);
        while (n < W && cyc < 200) begin
            case (mode)
                0: v = 1'b1;
                1: v = cyc[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            bit_valid = v;
            a = v ? va[W-1-n] : 1'($urandom_range(0, 1));
            b = v ? vb[W-1-n] : 1'($urandom_range(0, 1));
            start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (v) n++;
            if (n < W) begin
                check("no_early_done", {busy, done}, 2'b10);
                check("hold_mid", {lt, gt, eq}, prev_res);
            end
        end
        check("timeout", (cyc < 200) ? 1 : 0, 1);
        if (mode == 1) check("gap_cycles", cyc, 2 * W);
        if (mode == 0) check("cont_cycles", cyc, W);
        check("done_pulse", {busy, bit_ready, done}, 3'b001);
        check("result", {lt, gt, eq}, exp_res);
        start = 1'b1;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bit_valid = 1'b0;
        check("done_1cyc", {busy, bit_ready, done}, 3'b000);
        check("result_held", {lt, gt, eq}, exp_res);
        prev_res = exp_res;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a = 1'b0; b = 1'b0;
        prev_res = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {busy, bit_ready, done, lt, gt, eq}, 6'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmp(8'hA5, 8'hA5, 0);
        run_cmp(8'h80, 8'h7F, 0);
        run_cmp(8'h3C, 8'h3D, 0);
        run_cmp(8'h5A, 8'h5B, 1);

        // abort mid-comparison with reset
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; a = 1'b1; b = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bit_valid = 1'b0;
        check("rst_abort", {busy, bit_ready, done, lt, gt, eq}, 6'b0);
        @(posedge clk); #1;
        check("rst_no_done", {busy, done}, 2'b00);
        prev_res = 3'b000;
        run_cmp(8'h01, 8'h00, 0);

        for (int k = 0; k < 30; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (k % 4 == 0) ? ra : W'($urandom);
            if (k % 5 == 1) rb = ra ^ W'(1);
            run_cmp(ra, rb, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
